alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issue controller that sits in front of the unified 32-bit ALU (add, sub, mul, div, FP add) and sequences one operation at a time through it. It accepts requests over a valid/ready handshake, drives the ALU operand and select inputs, and waits a per-operation latency for the multi-cycle unit to settle. It then captures the ALU result into a holding register and presents it over a second valid/ready handshake. It also flags illegal select codes and counts completed operations.

## Interface
- ADD_LAT, 1: cycles from operands applied to ALU output valid, SR=0 and SR=1 (range 1..63)
- MUL_LAT, 4: same, SR=2
- DIV_LAT, 34: same, SR=3
- FP_LAT, 3: same, SR=4
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a, req_b  in  32  operands
- req_op  in  6  ALU select code
- alu_a, alu_b  out  32  registered operands to ALU A/B
- alu_sr  out  6  registered select to ALU SR
- alu_y  in  32  ALU output Y
- res_valid  out  1  result held
- res_ready  in  1  consumer takes result
- res_y  out  32  captured result
- res_err  out  1  request had illegal op (op > 4)
- busy  out  1  high in any state except IDLE
- ops_done  out  16  completed-operation counter, wraps

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_a/req_b/req_op into alu_a/alu_b/alu_sr, then go to ISSUE. For op>4, do not latch into alu_*; set err flag and go to DONE with res_y=0, res_err=1.
- ISSUE: load the 6-bit down-counter with the latency for alu_sr, then go to WAIT.
- WAIT: decrement each cycle. When the counter is 1, capture alu_y into res_y, set res_err=0, and go to DONE.
- DONE: res_valid=1. res_y and res_err stay stable until res_valid&&res_ready. On that handshake, increment ops_done, go to IDLE and clear res_valid. Illegal-op completions also increment ops_done.
- ops_done wraps 0xFFFF -> 0x0000.
- alu_a/alu_b/alu_sr hold their last issued values after completion. They change only on an accepted legal request.
- No overlap: a new request is never accepted while busy. req_valid outside IDLE is ignored.
- rst high in any state forces all of the following at the next edge, and any in-flight ALU result is discarded:
  - state=IDLE
  - res_valid=0, res_err=0, res_y=0
  - alu_a=alu_b=0, alu_sr=0
  - counter=0, ops_done=0

## Timing
- While rst is high: req_ready=0, busy=0. In the first cycle after rst falls: req_ready=1.
- Cycle numbering: cycle 0 is the cycle of the request handshake.
  - Cycle 1: ISSUE, new alu_* values visible.
  - Cycles 2 .. LAT+1: WAIT.
  - Edge ending cycle LAT+1: alu_y captured.
  - Cycle LAT+2: res_valid first high.
- Legal-op latency: request handshake to res_valid is LAT+2 cycles. Add/sub gives 3, mul 6, div 36, FP 5 at defaults.
- Illegal op: res_valid high in cycle 1.
- res_ready held high: DONE lasts exactly 1 cycle, and req_ready rises in the following cycle. Back-to-back add throughput is one result per 4 cycles.
- res_ready low: DONE is held indefinitely, and busy=1 throughout.
- Simultaneous req_valid and res_ready in DONE: the result handshake completes, and the request is not accepted until the IDLE cycle.

## Test plan
- Reset then add: req A=5, B=7, op=0 at cycle 0 -> alu_sr=0 in cycle 1; res_valid in cycle 3 with res_y=12, res_err=0; ops_done=1 after the handshake.
- Division latency: A=100, B=7, op=3 with DIV_LAT=34 -> res_valid exactly in cycle 36 with res_y=14; busy high in cycles 1..36.
- Illegal op: op=9, A=1, B=1 -> res_valid in cycle 1, res_y=0, res_err=1; alu_sr keeps its previous value; ops_done increments.
- Backpressure: sub A=10, B=3 with res_ready=0 for 20 cycles -> res_y=7 stable and req_ready=0 throughout; one res_ready pulse -> IDLE the next cycle.
- Reset mid-WAIT: mul issued, rst asserted in cycle 3 -> the next cycle shows res_valid=0, ops_done=0, alu_*=0, req_ready=0; the cycle after rst falls shows req_ready=1 and no stale result.
- Counter wrap: preload to 0xFFFF via 65535 adds (or force) -> one more completion gives ops_done=0x0000.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request and result handshake bundle between a client and the ALU issue sequencer.
interface alu_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [5:0]  req_op;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_y;
    logic        res_err;

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_y, res_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_y, res_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issues one operation at a time to the unified multi-cycle ALU, waits its
// latency, then holds the captured result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | operands on the ALU, latency counter loaded
// WAIT  | counting down ALU latency
// DONE  | result held, res_valid high
module alu_sequencer #(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 34,
    parameter int unsigned FP_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_sr,
    input  logic [31:0] alu_y,
    output logic        busy,
    output logic [15:0] ops_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [5:0] OP_MAX = 6'd4;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [5:0]  alu_sr_q, alu_sr_d;
    logic [31:0] res_y_q, res_y_d;
    logic        res_err_q, res_err_d;
    logic [15:0] ops_done_q, ops_done_d;
    logic [5:0]  lat_sel;

    always_comb begin
        case (alu_sr_q)
            6'd2:    lat_sel = 6'(MUL_LAT);
            6'd3:    lat_sel = 6'(DIV_LAT);
            6'd4:    lat_sel = 6'(FP_LAT);
            default: lat_sel = 6'(ADD_LAT);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sr_d   = alu_sr_q;
        res_y_d    = res_y_q;
        res_err_d  = res_err_q;
        ops_done_d = ops_done_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    // Illegal selects never reach the ALU; they complete directly.
                    if (bus.req_op > OP_MAX) begin
                        res_y_d   = 32'd0;
                        res_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        alu_a_d  = bus.req_a;
                        alu_b_d  = bus.req_b;
                        alu_sr_d = bus.req_op;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = lat_sel;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    res_y_d   = alu_y;
                    res_err_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            alu_a_q    <= 32'd0;
            alu_b_q    <= 32'd0;
            alu_sr_q   <= 6'd0;
            res_y_q    <= 32'd0;
            res_err_q  <= 1'b0;
            ops_done_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sr_q   <= alu_sr_d;
            res_y_q    <= res_y_d;
            res_err_q  <= res_err_d;
            ops_done_q <= ops_done_d;
        end
    end

    // Handshake outputs are gated so nothing looks ready or busy during reset.
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign busy          = (state_q != IDLE) && !rst;
    assign bus.res_valid = (state_q == DONE) && !rst;
    assign bus.res_y     = res_y_q;
    assign bus.res_err   = res_err_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sr        = alu_sr_q;
    assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a latency-aware ALU model that only
// presents a correct result once the operation's latency has elapsed.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [5:0]  alu_sr;
    logic        busy;
    logic [15:0] ops_done;
    int          checks = 0;
    int          failures = 0;
    int          age = 1000;
    logic [31:0] alu_settled;

    always #5 clk = ~clk;

    alu_seq_if sif ();

    alu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (sif),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sr   (alu_sr),
        .alu_y    (alu_y),
        .busy     (busy),
        .ops_done (ops_done)
    );

    function automatic int lat_of(input logic [5:0] sr);
        case (sr)
            6'd2:    return 4;
            6'd3:    return 34;
            6'd4:    return 3;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (sif.req_valid && sif.req_ready) age <= 0;
        else if (age < 1000) age <= age + 1;
    end

    always_comb begin
        alu_settled = 32'd0;
        case (alu_sr)
            6'd0: alu_settled = alu_a + alu_b;
            6'd1: alu_settled = alu_a - alu_b;
            6'd2: alu_settled = alu_a * alu_b;
            6'd3: alu_settled = (alu_b != 0) ? alu_a / alu_b : 32'd0;
            6'd4: alu_settled = alu_a + alu_b;
            default: alu_settled = 32'd0;
        endcase
        alu_y = (age >= lat_of(alu_sr)) ? alu_settled : 32'hBAD0_BAD0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        sif.req_a     = a;
        sif.req_b     = b;
        sif.req_op    = op;
        sif.req_valid = 1'b1;
        step();
        sif.req_valid = 1'b0;
    endtask

    task automatic take_result();
        sif.res_ready = 1'b1;
        step();
        sif.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sif.req_valid = 1'b0;
        sif.res_ready = 1'b0;
        sif.req_a = 32'd0;
        sif.req_b = 32'd0;
        sif.req_op = 6'd0;
        step();
        step();
        checks++;
        if (sif.req_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_busy got ready=%b busy=%b exp 0 0", sif.req_ready, busy);
        end
        checks++;
        if (sif.res_valid !== 1'b0 || sif.res_y !== 32'd0 || sif.res_err !== 1'b0 || ops_done !== 16'd0) begin
            failures++;
            $display("FAIL reset_result got valid=%b y=%h err=%b ops=%h exp 0", sif.res_valid, sif.res_y, sif.res_err, ops_done);
        end
        checks++;
        if ({alu_a, alu_b, alu_sr} !== 70'd0) begin
            failures++;
            $display("FAIL reset_alu got a=%h b=%h sr=%h exp 0", alu_a, alu_b, alu_sr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b exp 1", sif.req_ready);
        end
    endtask

    task automatic test_add();
        send(32'd5, 32'd7, 6'd0);
        checks++;
        if (alu_sr !== 6'd0 || alu_a !== 32'd5 || alu_b !== 32'd7 || busy !== 1'b1 || sif.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_issue got sr=%h a=%h b=%h busy=%b valid=%b exp 0 5 7 1 0", alu_sr, alu_a, alu_b, busy, sif.res_valid);
        end
        step();
        checks++;
        if (sif.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_cycle2_valid got %b exp 0", sif.res_valid);
        end
        step();
        checks++;
        if (sif.res_valid !== 1'b1 || sif.res_y !== 32'd12 || sif.res_err !== 1'b0) begin
            failures++;
            $display("FAIL add_result got valid=%b y=%0d err=%b exp 1 12 0", sif.res_valid, sif.res_y, sif.res_err);
        end
        take_result();
        checks++;
        if (sif.res_valid !== 1'b0 || ops_done !== 16'd1 || sif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_handshake got valid=%b ops=%0d ready=%b exp 0 1 1", sif.res_valid, ops_done, sif.req_ready);
        end
    endtask

    task automatic test_div();
        send(32'd100, 32'd7, 6'd3);
        for (int c = 1; c <= 36; c++) begin
            checks++;
            if (busy !== 1'b1 || sif.res_valid !== (c == 36)) begin
                failures++;
                $display("FAIL div_cycle%0d got busy=%b valid=%b exp 1 %b", c, busy, sif.res_valid, (c == 36));
            end
            if (c < 36) step();
        end
        checks++;
        if (sif.res_y !== 32'd14 || sif.res_err !== 1'b0) begin
            failures++;
            $display("FAIL div_result got y=%0d err=%b exp 14 0", sif.res_y, sif.res_err);
        end
        take_result();
        checks++;
        if (ops_done !== 16'd2) begin
            failures++;
            $display("FAIL div_ops got %0d exp 2", ops_done);
        end
    endtask

    task automatic test_illegal();
        send(32'd1, 32'd1, 6'd9);
        checks++;
        if (sif.res_valid !== 1'b1 || sif.res_y !== 32'd0 || sif.res_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_result got valid=%b y=%h err=%b exp 1 0 1", sif.res_valid, sif.res_y, sif.res_err);
        end
        checks++;
        if (alu_sr !== 6'd3 || alu_a !== 32'd100 || alu_b !== 32'd7) begin
            failures++;
            $display("FAIL illegal_alu_hold got sr=%h a=%0d b=%0d exp 3 100 7", alu_sr, alu_a, alu_b);
        end
        take_result();
        checks++;
        if (ops_done !== 16'd3 || sif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL illegal_ops got ops=%0d ready=%b exp 3 1", ops_done, sif.req_ready);
        end
    endtask

    task automatic test_backpressure();
        send(32'd10, 32'd3, 6'd1);
        step();
        step();
        sif.req_a     = 32'd2;
        sif.req_b     = 32'd3;
        sif.req_op    = 6'd0;
        sif.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (sif.res_valid !== 1'b1 || sif.res_y !== 32'd7 || sif.req_ready !== 1'b0 || busy !== 1'b1 || alu_a !== 32'd10) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b y=%0d ready=%b busy=%b a=%0d exp 1 7 0 1 10",
                         i, sif.res_valid, sif.res_y, sif.req_ready, busy, alu_a);
            end
            step();
        end
        sif.res_ready = 1'b1;
        step();
        sif.res_ready = 1'b0;
        checks++;
        if (sif.res_valid !== 1'b0 || sif.req_ready !== 1'b1 || ops_done !== 16'd4) begin
            failures++;
            $display("FAIL bp_release got valid=%b ready=%b ops=%0d exp 0 1 4", sif.res_valid, sif.req_ready, ops_done);
        end
        step();
        sif.req_valid = 1'b0;
        checks++;
        if (alu_a !== 32'd2 || alu_sr !== 6'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_next_issue got a=%0d sr=%h busy=%b exp 2 0 1", alu_a, alu_sr, busy);
        end
        step();
        step();
        checks++;
        if (sif.res_valid !== 1'b1 || sif.res_y !== 32'd5) begin
            failures++;
            $display("FAIL bp_next_result got valid=%b y=%0d exp 1 5", sif.res_valid, sif.res_y);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        sif.req_a     = 32'd1;
        sif.req_b     = 32'd2;
        sif.req_op    = 6'd0;
        sif.req_valid = 1'b1;
        sif.res_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (sif.res_valid !== (c % 4 == 3) || sif.req_ready !== (c % 4 == 0)) begin
                failures++;
                $display("FAIL b2b_cycle%0d got valid=%b ready=%b exp %b %b",
                         c, sif.res_valid, sif.req_ready, (c % 4 == 3), (c % 4 == 0));
            end
            if (c % 4 == 3) begin
                checks++;
                if (sif.res_y !== 32'd3) begin
                    failures++;
                    $display("FAIL b2b_y%0d got %0d exp 3", c, sif.res_y);
                end
            end
            if (c == 11) sif.req_valid = 1'b0;
            step();
        end
        sif.res_ready = 1'b0;
        checks++;
        if (ops_done !== 16'd8 || sif.req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got ops=%0d ready=%b busy=%b exp 8 1 0", ops_done, sif.req_ready, busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        send(32'd6, 32'd7, 6'd2);
        step();
        step();
        checks++;
        if (busy !== 1'b1 || sif.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmw_pre got busy=%b valid=%b exp 1 0", busy, sif.res_valid);
        end
        rst = 1'b1;
        step();
        checks++;
        if (sif.res_valid !== 1'b0 || ops_done !== 16'd0 || sif.req_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rmw_reset got valid=%b ops=%0d ready=%b busy=%b exp 0 0 0 0", sif.res_valid, ops_done, sif.req_ready, busy);
        end
        checks++;
        if ({alu_a, alu_b, alu_sr} !== 70'd0 || sif.res_y !== 32'd0 || sif.res_err !== 1'b0) begin
            failures++;
            $display("FAIL rmw_regs got a=%h b=%h sr=%h y=%h err=%b exp 0", alu_a, alu_b, alu_sr, sif.res_y, sif.res_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sif.req_ready !== 1'b1 || sif.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmw_release got ready=%b valid=%b exp 1 0", sif.req_ready, sif.res_valid);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (sif.res_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rmw_stale%0d got valid=%b busy=%b exp 0 0", i, sif.res_valid, busy);
            end
        end
    endtask

    task automatic test_wrap();
        force dut.ops_done_q = 16'hFFFF;
        step();
        release dut.ops_done_q;
        checks++;
        if (ops_done !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload got %h exp ffff", ops_done);
        end
        send(32'd4, 32'd4, 6'd0);
        step();
        step();
        checks++;
        if (sif.res_valid !== 1'b1 || sif.res_y !== 32'd8) begin
            failures++;
            $display("FAIL wrap_result got valid=%b y=%0d exp 1 8", sif.res_valid, sif.res_y);
        end
        take_result();
        checks++;
        if (ops_done !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_count got %h exp 0000", ops_done);
        end
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog time limit reached exp bench completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        test_reset();
        test_add();
        test_div();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
